// File: rtl/poly_mul_ctrl.sv
// ---------------------------------------------------------------------------
// poly_mul_ctrl
//
// Sequencer wrapped around the LAC ternary polynomial multiplier. It collects
// polynomials a and r from a host stream one coefficient per beat and packs
// them into the multiplier's wide operand buses. It then releases the
// multiplier (o_mul_reset low) and waits for done under a watchdog. Finally it
// streams c[k] = (sum_one[k] - sum_mone[k]) mod Q back out, one coefficient
// per beat.
//
// Parameters
//   WIDTH    coefficient width of a and of the multiplier sums
//   N        polynomial length
//   Q        modulus used by the final subtraction
//   TIMEOUT  RUN cycles allowed before the watchdog aborts
//
// Ports
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_start               start pulse, honoured only when idle
//   i_clear               clears the sticky o_error flag
//   i_coef_valid/o_coef_ready, i_coef_a, i_coef_r
//                         load stream for a[k] and r[k]
//   o_mul_reset           multiplier reset/start (low = run)
//   o_mul_poly_a/r        packed operands; a[k] at [k*WIDTH +: WIDTH],
//                         r[k] at [k*(WIDTH+1) +: WIDTH+1]
//   i_mul_sum_one/mone    multiplier +1 / -1 accumulations
//   i_mul_done            multiplier done
//   o_res_valid/i_res_ready, o_res_data, o_res_last
//                         result stream, o_res_last marks c[N-1]
//   o_busy                controller not idle
//   o_done                one-cycle pulse after the last result is taken
//   o_error               sticky watchdog flag
//
// Optional feature (macro POLY_MUL_CTRL_CYCLE_COUNT_EN)
//   o_run_cycles          RUN-cycle count of the last multiplication, or
//                         TIMEOUT when the watchdog fired
// ---------------------------------------------------------------------------
module poly_mul_ctrl #(
  parameter int WIDTH   = 8,
  parameter int N       = 512,
  parameter int Q       = 251,
  parameter int TIMEOUT = 70000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_clear,
  input  logic                   i_coef_valid,
  output logic                   o_coef_ready,
  input  logic [WIDTH-1:0]       i_coef_a,
  input  logic [WIDTH:0]         i_coef_r,
  output logic                   o_mul_reset,
  output logic [WIDTH*N-1:0]     o_mul_poly_a,
  output logic [(WIDTH+1)*N-1:0] o_mul_poly_r,
  input  logic [WIDTH*N-1:0]     i_mul_sum_one,
  input  logic [WIDTH*N-1:0]     i_mul_sum_mone,
  input  logic                   i_mul_done,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [WIDTH-1:0]       o_res_data,
  output logic                   o_res_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
`ifdef POLY_MUL_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]            o_run_cycles
`endif
);

  localparam int                IDXW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(N - 1);
  localparam logic [31:0]       WD_LAST  = 32'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0]  Q_W      = WIDTH'(Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_OUT,
    S_ERR
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [IDXW-1:0]          r_idx;
  logic [IDXW-1:0]          w_idxNext;
  logic [31:0]              r_wd;
  logic [WIDTH*N-1:0]       r_polyA;
  logic [(WIDTH+1)*N-1:0]   r_polyR;
  logic                     r_mulReset;
  logic                     r_done;
  logic                     r_error;
  logic [WIDTH-1:0]         w_sumOne;
  logic [WIDTH-1:0]         w_sumMone;
  logic [WIDTH:0]           w_diff;
  logic [WIDTH-1:0]         w_wrapped;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic. In RUN a done in the final watchdog cycle still wins.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_nextState = S_LOAD;
      S_LOAD: if (i_coef_valid && (r_idx == IDX_LAST)) w_nextState = S_RUN;
      S_RUN: begin
        if (i_mul_done)            w_nextState = S_OUT;
        else if (r_wd == WD_LAST)  w_nextState = S_ERR;
      end
      S_OUT:  if (i_res_ready && (r_idx == IDX_LAST)) w_nextState = S_IDLE;
      S_ERR:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output logic decoded from the current state.
  always_comb begin
    o_coef_ready = (r_state == S_LOAD);
    o_res_valid  = (r_state == S_OUT);
    o_res_last   = (r_state == S_OUT) && (r_idx == IDX_LAST);
    o_busy       = (r_state != S_IDLE);
    o_res_data   = w_diff[WIDTH] ? w_wrapped : w_diff[WIDTH-1:0];
  end

  // Result datapath: the sums are already in [0, Q-1], so a single
  // conditional add of Q brings a negative difference back into range.
  // Adding Q modulo 2^WIDTH to the low bits gives the same result as the
  // full-width sum because that result always fits in WIDTH bits.
  assign w_sumOne  = i_mul_sum_one[r_idx*WIDTH +: WIDTH];
  assign w_sumMone = i_mul_sum_mone[r_idx*WIDTH +: WIDTH];
  assign w_diff    = {1'b0, w_sumOne} - {1'b0, w_sumMone};
  assign w_wrapped = w_diff[WIDTH-1:0] + Q_W;

  assign w_idxNext = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  // Shared coefficient index: walks the load stream and then the result
  // stream, and is back at 0 whenever the controller leaves either phase.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_idx <= '0;
    end else begin
      case (r_state)
        S_LOAD:  if (i_coef_valid) r_idx <= w_idxNext;
        S_OUT:   if (i_res_ready)  r_idx <= w_idxNext;
        default: r_idx <= '0;
      endcase
    end
  end

  // Watchdog counts RUN cycles from 0 and is idle at 0 otherwise.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_wd <= '0;
    else if (r_state == S_RUN) r_wd <= r_wd + 32'd1;
    else r_wd <= '0;
  end

  // Operand registers only change during LOAD, so the buses stay frozen
  // through RUN and OUT.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_polyA <= '0;
      r_polyR <= '0;
    end else if ((r_state == S_LOAD) && i_coef_valid) begin
      r_polyA[r_idx*WIDTH +: WIDTH]         <= i_coef_a;
      r_polyR[r_idx*(WIDTH+1) +: WIDTH + 1] <= i_coef_r;
    end
  end

  // o_mul_reset is registered from the next state, so it drops on the first
  // RUN cycle and rises again on ERR or IDLE without combinational glitches.
  // The error flag is set on entry to ERR and takes priority over i_clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mulReset <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_mulReset <= !((w_nextState == S_RUN) || (w_nextState == S_OUT));
      r_done     <= (r_state == S_OUT) && i_res_ready && (r_idx == IDX_LAST);
      if (w_nextState == S_ERR) r_error <= 1'b1;
      else if (i_clear)         r_error <= 1'b0;
    end
  end

  assign o_mul_reset  = r_mulReset;
  assign o_mul_poly_a = r_polyA;
  assign o_mul_poly_r = r_polyR;
  assign o_done       = r_done;
  assign o_error      = r_error;

`ifdef POLY_MUL_CTRL_CYCLE_COUNT_EN
  logic [31:0] r_runCycles;

  // The count includes the RUN cycle in which done (or the timeout) is seen,
  // which makes the timeout case equal TIMEOUT.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_runCycles <= '0;
    end else if (r_state == S_RUN) begin
      if (i_mul_done)           r_runCycles <= r_wd + 32'd1;
      else if (r_wd == WD_LAST) r_runCycles <= 32'(TIMEOUT);
    end
  end

  assign o_run_cycles = r_runCycles;
`endif

endmodule
